// File: rtl/iot_filter_param_if.sv
// Beat-in / result-out bus of the parametrised IoT filter.
// The host drives beats and configuration; the filter returns busy, valid and the result.
interface iot_filter_param_if #(
    parameter int IN_W   = 8,
    parameter int WORD_W = 128
);
    logic              in_en;
    logic [IN_W-1:0]   iot_in;
    logic [2:0]        fn_sel;
    logic [WORD_W-1:0] lo_bound;
    logic [WORD_W-1:0] hi_bound;
    logic              busy;
    logic              valid;
    logic [WORD_W-1:0] iot_out;

    modport master (
        output in_en, iot_in, fn_sel, lo_bound, hi_bound,
        input  busy, valid, iot_out
    );

    modport slave (
        input  in_en, iot_in, fn_sel, lo_bound, hi_bound,
        output busy, valid, iot_out
    );
endinterface

// File: rtl/iot_filter_param.sv
// Parametrised IoT data filter: assembles IN_W-bit beats into WORD_W-bit words and
// applies a per-word (extract/exclude) or per-round (max/min/avg/peak) function.
module iot_filter_param #(
    parameter int IN_W  = 8,
    parameter int BEATS = 16,
    parameter int WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    iot_filter_param_if.slave bus
);
    localparam int WORD_W = IN_W * BEATS;
    localparam int LOG2W  = $clog2(WORDS);
    localparam int AW     = WORD_W + LOG2W;
    localparam int BCW    = $clog2(BEATS);

    typedef enum logic [2:0] {
        FN_NONE     = 3'd0,
        FN_MAX      = 3'd1,
        FN_MIN      = 3'd2,
        FN_AVG      = 3'd3,
        FN_EXTRACT  = 3'd4,
        FN_EXCLUDE  = 3'd5,
        FN_PEAK_MAX = 3'd6,
        FN_PEAK_MIN = 3'd7
    } fn_e;

    typedef enum logic {
        ST_COLLECT,
        ST_EVAL
    } state_e;

    state_e            state, state_nx;
    logic [BCW-1:0]    beat_cnt;
    logic [LOG2W-1:0]  word_cnt;
    logic [WORD_W-1:0] word;
    logic [AW-1:0]     acc;
    logic [WORD_W-1:0] peak;
    logic              peak_vld;
    fn_e               cfg_fn;
    logic [WORD_W-1:0] cfg_lo;
    logic [WORD_W-1:0] cfg_hi;
    logic              valid_r;
    logic [WORD_W-1:0] out_r;

    logic              busy;
    logic              accept;
    logic              beat_last;
    logic              first_word;
    logic              last_word;
    logic [AW-1:0]     wide;
    logic [AW-1:0]     acc_nx;
    logic [WORD_W-1:0] round_val;
    logic [WORD_W-1:0] peak_nx;
    logic              peak_vld_nx;
    logic              res_vld;
    logic [WORD_W-1:0] res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = (state == ST_EVAL);
        accept      = bus.in_en && !busy;
        beat_last   = (beat_cnt == BCW'(BEATS - 1));
        first_word  = (word_cnt == '0);
        last_word   = (word_cnt == LOG2W'(WORDS - 1));
        wide        = {{LOG2W{1'b0}}, word};
        acc_nx      = acc;
        round_val   = '0;
        peak_nx     = peak;
        peak_vld_nx = peak_vld;
        res_vld     = 1'b0;
        res         = '0;

        case (state)
            ST_COLLECT: begin
                if (accept && beat_last) begin
                    state_nx = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_nx = ST_COLLECT;
                case (cfg_fn)
                    FN_MAX, FN_PEAK_MAX: acc_nx = (first_word || wide > acc) ? wide : acc;
                    FN_MIN, FN_PEAK_MIN: acc_nx = (first_word || wide < acc) ? wide : acc;
                    FN_AVG:              acc_nx = first_word ? wide : acc + wide;
                    FN_EXTRACT: begin
                        res_vld = (cfg_lo < word) && (word < cfg_hi);
                        res     = word;
                    end
                    FN_EXCLUDE: begin
                        res_vld = (word < cfg_lo) || (word > cfg_hi);
                        res     = word;
                    end
                    default: ;
                endcase

                // Round result reuses the accumulator value produced by this last word.
                round_val = acc_nx[WORD_W-1:0];
                if (last_word) begin
                    case (cfg_fn)
                        FN_MAX, FN_MIN: begin
                            res_vld = 1'b1;
                            res     = round_val;
                        end
                        FN_AVG: begin
                            res_vld = 1'b1;
                            res     = WORD_W'(acc_nx >> LOG2W);
                        end
                        FN_PEAK_MAX: begin
                            if (!peak_vld || round_val > peak) begin
                                res_vld     = 1'b1;
                                res         = round_val;
                                peak_nx     = round_val;
                                peak_vld_nx = 1'b1;
                            end
                        end
                        FN_PEAK_MIN: begin
                            if (!peak_vld || round_val < peak) begin
                                res_vld     = 1'b1;
                                res         = round_val;
                                peak_nx     = round_val;
                                peak_vld_nx = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nx = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            word     <= '0;
            acc      <= '0;
            peak     <= '0;
            peak_vld <= 1'b0;
            cfg_fn   <= FN_NONE;
            cfg_lo   <= '0;
            cfg_hi   <= '0;
            valid_r  <= 1'b0;
            out_r    <= '0;
        end else begin
            valid_r <= 1'b0;
            out_r   <= '0;

            if (accept) begin
                word     <= {word[WORD_W-IN_W-1:0], bus.iot_in};
                beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                // Configuration is frozen for the whole round at its first beat.
                if (beat_cnt == '0 && word_cnt == '0) begin
                    cfg_fn <= fn_e'(bus.fn_sel);
                    cfg_lo <= bus.lo_bound;
                    cfg_hi <= bus.hi_bound;
                    if (fn_e'(bus.fn_sel) != cfg_fn) begin
                        peak_vld <= 1'b0;
                    end
                end
            end

            if (state == ST_EVAL) begin
                acc      <= acc_nx;
                peak     <= peak_nx;
                peak_vld <= peak_vld_nx;
                valid_r  <= res_vld;
                out_r    <= res_vld ? res : '0;
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.valid   = valid_r;
    assign bus.iot_out = out_r;

endmodule

// File: tb/tb_iot_filter_param.sv
// Scoreboard bench for iot_filter_param: expected results are queued as stimulus is
// driven and compared (data and 2-cycle latency) when the filter raises valid.
module tb_iot_filter_param;
    localparam int IN_W   = 8;
    localparam int BEATS  = 16;
    localparam int WORDS  = 8;
    localparam int WORD_W = IN_W * BEATS;

    typedef logic [WORD_W-1:0] word_t;
    typedef struct {
        word_t data;
        int    due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    word_t   tb_peak = '0;
    logic    tb_pv = 1'b0;
    int      tb_last_fn = 0;

    iot_filter_param_if #(.IN_W(IN_W), .WORD_W(WORD_W)) bus ();

    iot_filter_param #(.IN_W(IN_W), .BEATS(BEATS), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Output monitor: every valid must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        if (bus.valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.iot_out, e.data);
                check("latency", word_t'(cyc), word_t'(e.due));
            end
        end else if (bus.iot_out != '0) begin
            check("out_zero_when_idle", bus.iot_out, '0);
        end
    end

    // Presents a beat and holds it until accepted (busy low at the clock edge).
    task automatic send_beat(input logic [IN_W-1:0] b);
        int guard = 0;
        bus.in_en  = 1'b1;
        bus.iot_in = b;
        while (bus.busy && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) check("busy_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic send_word(input word_t w);
        for (int b = BEATS - 1; b >= 0; b--) send_beat(w[b*IN_W +: IN_W]);
    endtask

    task automatic push_exp(input word_t d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic run_round(input int fn, input word_t lo, input word_t hi, input word_t w [WORDS]);
        word_t mx, mn;
        logic [WORD_W+2:0] sum;
        logic round_out;
        word_t round_res;
        mx = w[0];
        mn = w[0];
        sum = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (w[k] > mx) mx = w[k];
            if (w[k] < mn) mn = w[k];
            sum = sum + {3'b000, w[k]};
        end
        if (fn != tb_last_fn) tb_pv = 1'b0;
        tb_last_fn = fn;
        round_out = 1'b0;
        round_res = '0;
        case (fn)
            1: begin round_out = 1'b1; round_res = mx; end
            2: begin round_out = 1'b1; round_res = mn; end
            3: begin round_out = 1'b1; round_res = sum[WORD_W+2:3]; end
            6: if (!tb_pv || mx > tb_peak) begin
                   round_out = 1'b1; round_res = mx; tb_peak = mx; tb_pv = 1'b1;
               end
            7: if (!tb_pv || mn < tb_peak) begin
                   round_out = 1'b1; round_res = mn; tb_peak = mn; tb_pv = 1'b1;
               end
            default: ;
        endcase

        bus.fn_sel   = 3'(fn);
        bus.lo_bound = lo;
        bus.hi_bound = hi;
        for (int k = 0; k < WORDS; k++) begin
            send_word(w[k]);
            if (fn == 4 && lo < w[k] && w[k] < hi) push_exp(w[k], cyc + 1);
            if (fn == 5 && (w[k] < lo || w[k] > hi)) push_exp(w[k], cyc + 1);
            if (k == WORDS - 1 && round_out) push_exp(round_res, cyc + 1);
            // Changing the selection after the first beat must not affect the round.
            if (k == 2) bus.fn_sel = 3'(fn ^ 3);
        end
    endtask

    task automatic idle(input int n);
        bus.in_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    word_t w [WORDS];

    initial begin
        bus.in_en    = 1'b0;
        bus.iot_in   = '0;
        bus.fn_sel   = '0;
        bus.lo_bound = '0;
        bus.hi_bound = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", word_t'(bus.busy), 0);
        check("reset_valid", word_t'(bus.valid), 0);
        check("reset_out", bus.iot_out, '0);

        // MAX over 1..8
        for (int k = 0; k < WORDS; k++) w[k] = word_t'(k + 1);
        run_round(1, '0, '0, w);
        idle(3);

        // AVG floor, then all-ones without wrap
        w = '{word_t'(1), word_t'(2), word_t'(3), word_t'(4), word_t'(5), word_t'(6), word_t'(7), word_t'(9)};
        run_round(3, '0, '0, w);
        for (int k = 0; k < WORDS; k++) w[k] = '1;
        run_round(3, '0, '0, w);

        // EXTRACT: bounds exclusive
        w = '{word_t'('h10), word_t'('h11), word_t'('h1F), word_t'('h20), word_t'(0), word_t'('h21), word_t'('h15), '1};
        run_round(4, word_t'('h10), word_t'('h20), w);

        // EXCLUDE with lo >= hi, MIN, and none
        w = '{word_t'('h05), word_t'('h10), word_t'('h30), word_t'('h40), word_t'('h20), word_t'('h2F), word_t'(0), '1};
        run_round(5, word_t'('h30), word_t'('h10), w);
        w = '{word_t'('h50), word_t'('h10), word_t'('h30), word_t'('h40), word_t'('h0C), word_t'('h2F), word_t'('h77), '1};
        run_round(2, '0, '0, w);
        run_round(0, '0, '0, w);
        idle(2);

        // PEAK_MAX: round maxes 5,3,5,9, then PEAK_MIN
        for (int r = 0; r < 4; r++) begin
            int pk;
            pk = (r == 0) ? 5 : (r == 1) ? 3 : (r == 2) ? 5 : 9;
            for (int k = 0; k < WORDS; k++) w[k] = word_t'((k == 3) ? pk : 2);
            run_round(6, '0, '0, w);
        end
        for (int k = 0; k < WORDS; k++) w[k] = word_t'(k + 4);
        run_round(7, '0, '0, w);
        idle(3);

        // Free-running in_en ignoring busy: the beat during each busy cycle is lost.
        begin
            int c0;
            bus.fn_sel   = 3'd4;
            bus.lo_bound = '0;
            bus.hi_bound = '1;
            c0 = cyc;
            for (int k = 0; k < WORDS; k++) begin
                word_t ew;
                ew = '0;
                for (int b = 0; b < BEATS; b++) ew = {ew[WORD_W-IN_W-1:0], 8'(17 * k + b + 1)};
                push_exp(ew, c0 + 17 * k + 17);
            end
            for (int i = 0; i < 17 * WORDS; i++) begin
                bus.in_en  = 1'b1;
                bus.iot_in = 8'(i + 1);
                if (i == 40) bus.fn_sel = 3'd1;
                @(negedge clk);
            end
            tb_last_fn = 4;
            idle(3);
        end

        // Reset mid-word: partial word discarded, fresh round afterwards.
        bus.fn_sel = 3'd1;
        for (int b = 0; b < 7; b++) send_beat(8'hEE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_en = 1'b0;
        check("rst_valid", word_t'(bus.valid), 0);
        check("rst_busy", word_t'(bus.busy), 0);
        check("rst_out", bus.iot_out, '0);
        tb_pv = 1'b0;
        tb_last_fn = 0;
        w = '{word_t'('h31), word_t'('h02), word_t'('h63), word_t'('h14), word_t'('h05), word_t'('h46), word_t'('h17), word_t'('h08)};
        run_round(1, '0, '0, w);
        idle(6);

        check("scoreboard_drained", word_t'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
